// File: rtl/vpu_exec_unit.sv
// Clocked VPU execute unit: in-order GPR/SGPR datapath with a valid/ready instruction port.
// Define VPU_FAST_MUL_EN for a single-cycle multiplier; otherwise MUL iterates over DW cycles.
module vpu_exec_unit #(
    parameter int DW   = 16,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    output logic          done,
    output logic          err,
    output logic [2:0]    flags,
    output logic [DW-1:0] sgpr,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);
    localparam int AW = $clog2(NREG);

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_AND     = 5'd5;
    localparam logic [4:0] OP_OR      = 5'd6;
    localparam logic [4:0] OP_XOR     = 5'd7;

`ifdef VPU_FAST_MUL_EN
    typedef enum logic [0:0] {ST_IDLE, ST_EXEC} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL} state_t;
    localparam int CW = $clog2(DW);
`endif

    function automatic logic out_of_range(input logic [4:0] idx);
        return 32'(idx) >= NREG;
    endfunction

    function automatic logic uses_rsrc2(input logic [4:0] op, input logic imm_mode);
        return !imm_mode && (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    state_t          state_reg;
    logic [31:0]     ir_reg;
    logic            ir_ill_reg;
    logic            done_reg;
    logic            err_reg;
    logic [2:0]      flags_reg;
    logic [DW-1:0]   sgpr_reg;
    logic [DW-1:0]   gpr_reg [NREG];

    // Legality is decided on the raw instruction so an illegal MUL never enters the engine.
    logic [4:0]      in_op;
    logic            in_ill;
    assign in_op  = instr[31:27];
    assign in_ill = (in_op > OP_XOR) || out_of_range(instr[26:22]) || out_of_range(instr[21:17])
                  || (uses_rsrc2(in_op, instr[16]) && out_of_range(instr[15:11]));

    logic [4:0]      ex_op;
    logic [DW-1:0]   ex_imm;
    logic [DW-1:0]   ex_a;
    logic [DW-1:0]   ex_b;
    logic [DW:0]     add_sum;
    logic [DW-1:0]   alu_res;
    logic            alu_carry;

    assign ex_op   = ir_reg[31:27];
    assign ex_imm  = DW'(ir_reg[15:0]);
    assign ex_a    = gpr_reg[ir_reg[17 +: AW]];
    assign ex_b    = ir_reg[16] ? ex_imm : gpr_reg[ir_reg[11 +: AW]];
    assign add_sum = {1'b0, ex_a} + {1'b0, ex_b};

`ifdef VPU_FAST_MUL_EN
    logic [2*DW-1:0] fast_prod;
    assign fast_prod = (2*DW)'(ex_a) * (2*DW)'(ex_b);
`else
    logic [DW-1:0]   mcand_reg;
    logic [2*DW-1:0] prod_reg;
    logic [CW-1:0]   cnt_reg;
    logic [DW-1:0]   acc_a;
    logic [DW-1:0]   acc_b;
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] prod_next;
    logic            mul_last;

    // Shift-add: the multiplier sits in the low half and shifts out as the product shifts in.
    assign acc_a     = gpr_reg[instr[17 +: AW]];
    assign acc_b     = instr[16] ? DW'(instr[15:0]) : gpr_reg[instr[11 +: AW]];
    assign mul_sum   = {1'b0, prod_reg[2*DW-1:DW]} + (prod_reg[0] ? {1'b0, mcand_reg} : '0);
    assign prod_next = {mul_sum, prod_reg[DW-1:1]};
    assign mul_last  = (cnt_reg == CW'(DW - 1));
`endif

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (ex_op)
            OP_MOVSGPR: alu_res = sgpr_reg;
            OP_MOV:     alu_res = ir_reg[16] ? ex_imm : ex_a;
            OP_ADD:     {alu_carry, alu_res} = add_sum;
            OP_SUB: begin
                alu_res   = ex_a - ex_b;
                alu_carry = ex_a < ex_b;
            end
            OP_AND:     alu_res = ex_a & ex_b;
            OP_OR:      alu_res = ex_a | ex_b;
            OP_XOR:     alu_res = ex_a ^ ex_b;
`ifdef VPU_FAST_MUL_EN
            OP_MUL:     alu_res = fast_prod[DW-1:0];
`endif
            default:    alu_res = '0;
        endcase
    end

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] wr_sel;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ir_reg[22 +: AW];
        wr_data = alu_res;
        if (state_reg == ST_EXEC && !ir_ill_reg) begin
            wr_en = 1'b1;
        end
`ifndef VPU_FAST_MUL_EN
        if (state_reg == ST_MUL && mul_last) begin
            wr_en   = 1'b1;
            wr_data = prod_next[DW-1:0];
        end
`endif
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) gpr_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) if (wr_sel[i]) gpr_reg[i] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            ir_reg     <= '0;
            ir_ill_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            flags_reg  <= '0;
            sgpr_reg   <= '0;
`ifndef VPU_FAST_MUL_EN
            mcand_reg  <= '0;
            prod_reg   <= '0;
            cnt_reg    <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        ir_reg     <= instr;
                        ir_ill_reg <= in_ill;
                        state_reg  <= ST_EXEC;
`ifndef VPU_FAST_MUL_EN
                        if (!in_ill && in_op == OP_MUL) begin
                            state_reg <= ST_MUL;
                            cnt_reg   <= '0;
                            mcand_reg <= acc_a;
                            prod_reg  <= {{DW{1'b0}}, acc_b};
                        end
`endif
                    end
                end
                ST_EXEC: begin
                    state_reg <= ST_IDLE;
                    if (ir_ill_reg) begin
                        err_reg <= 1'b1;
                    end else begin
                        done_reg  <= 1'b1;
                        flags_reg <= {alu_carry, alu_res[DW-1], alu_res == '0};
`ifdef VPU_FAST_MUL_EN
                        if (ex_op == OP_MUL) sgpr_reg <= fast_prod[2*DW-1:DW];
`endif
                    end
                end
`ifndef VPU_FAST_MUL_EN
                ST_MUL: begin
                    prod_reg <= prod_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (mul_last) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                        sgpr_reg  <= prod_next[2*DW-1:DW];
                        flags_reg <= {1'b0, prod_next[DW-1], prod_next[DW-1:0] == '0};
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state_reg == ST_IDLE);
    assign done     = done_reg;
    assign err      = err_reg;
    assign flags    = flags_reg;
    assign sgpr     = sgpr_reg;
    assign dbg_data = (32'(dbg_addr) >= NREG) ? '0 : gpr_reg[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_vpu_exec_unit.sv
// Scoreboard bench for vpu_exec_unit (DW=16, NREG=32 main instance, NREG=8 for index checks).
// Honours VPU_FAST_MUL_EN for the expected MUL latency.
module tb_vpu_exec_unit;
    localparam int DW = 16;
`ifdef VPU_FAST_MUL_EN
    localparam int MUL_LAT  = 2;
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_LAT  = DW + 1;
    localparam int MUL_BUSY = DW;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, done, err;
    logic [31:0]   instr;
    logic [2:0]    flags;
    logic [DW-1:0] sgpr, dbg_data;
    logic [4:0]    dbg_addr, main_addr, mon_addr;
    logic          mon_active;

    logic          in_valid8, in_ready8, done8, err8;
    logic [31:0]   instr8;
    logic [2:0]    flags8;
    logic [DW-1:0] sgpr8, dbg_data8;
    logic [4:0]    dbg_addr8;

    always #5 clk = ~clk;
    assign dbg_addr = mon_active ? mon_addr : main_addr;

    vpu_exec_unit #(.DW(DW), .NREG(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .done(done), .err(err), .flags(flags), .sgpr(sgpr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    vpu_exec_unit #(.DW(DW), .NREG(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .instr(instr8),
        .done(done8), .err(err8), .flags(flags8), .sgpr(sgpr8),
        .dbg_addr(dbg_addr8), .dbg_data(dbg_data8)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic          is_err;
        logic [4:0]    rd;
        logic [DW-1:0] data;
        logic [DW-1:0] sgpr;
        logic [2:0]    flags;
        int            lat;
        int            acc_cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model_gpr [32];
    logic [DW-1:0] model_sgpr;
    logic [2:0]    model_flags;

    function automatic logic [31:0] enc_r(input logic [4:0] op, rd, rs1, rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, rd, rs1, input logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] op;
        op = ($urandom_range(0, 11) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
        return {op, 5'($urandom), 5'($urandom), 1'($urandom), 16'($urandom)};
    endfunction

    // Reference behaviour: updates the architectural model and returns what retirement must show.
    task automatic predict(input logic [31:0] w, output exp_t e);
        logic [4:0]      op, rd, rs1, rs2;
        logic            im, c, ill;
        logic [DW-1:0]   a, b, r;
        logic [DW:0]     s;
        logic [2*DW-1:0] p;
        op = w[31:27]; rd = w[26:22]; rs1 = w[21:17]; im = w[16]; rs2 = w[15:11];
        a = model_gpr[rs1];
        b = im ? w[15:0] : model_gpr[rs2];
        ill = (op > 5'd7);
        c = 1'b0; r = '0;
        e.lat = 2;
        case (op)
            5'd0: r = model_sgpr;
            5'd1: r = im ? w[15:0] : a;
            5'd2: begin s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW]; end
            5'd3: begin r = a - b; c = (a < b); end
            5'd4: begin
                p = (2*DW)'(a) * (2*DW)'(b);
                r = p[DW-1:0];
                model_sgpr = p[2*DW-1:DW];
                e.lat = MUL_LAT;
            end
            5'd5: r = a & b;
            5'd6: r = a | b;
            5'd7: r = a ^ b;
            default: r = '0;
        endcase
        if (!ill) begin
            model_gpr[rd] = r;
            model_flags = {c, r[DW-1], r == '0};
        end
        e.is_err = ill;
        e.rd     = rd;
        e.data   = model_gpr[rd];
        e.flags  = model_flags;
        e.sgpr   = model_sgpr;
        e.acc_cyc = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_gpr[i] = '0;
        model_sgpr  = '0;
        model_flags = '0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: retire checks first, then record any accept happening at the coming edge.
    initial begin
        exp_t e;
        mon_active = 1'b0;
        mon_addr   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                if (done || err) begin
                    if (sb_q.size() == 0) begin
                        check_eq("spurious_pulse", {30'd0, done, err}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        mon_addr   = e.rd;
                        mon_active = 1'b1;
                        #1;
                        $display("retire rd=%0d err=%0b data=0x%04h flags=%03b sgpr=0x%04h",
                                 e.rd, err, dbg_data, flags, sgpr);
                        check_eq("err_pulse", {31'd0, err}, {31'd0, e.is_err});
                        check_eq("done_pulse", {31'd0, done}, {31'd0, !e.is_err});
                        check_eq("rdst_value", {16'd0, dbg_data}, {16'd0, e.data});
                        check_eq("flags", {29'd0, flags}, {29'd0, e.flags});
                        check_eq("sgpr", {16'd0, sgpr}, {16'd0, e.sgpr});
                        check_eq("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
                        mon_active = 1'b0;
                    end
                end
                if (in_valid && in_ready) begin
                    predict(instr, e);
                    e.acc_cyc = cyc;
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int n = 0;
        @(negedge clk);
        instr    = w;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_empty", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic peek(input logic [4:0] a, input logic [15:0] exp, input string tag);
        main_addr = a;
        #1;
        check_eq(tag, {16'd0, dbg_data}, {16'd0, exp});
    endtask

    task automatic run8(input logic [31:0] w, output logic got_done, output logic got_err);
        @(negedge clk);
        instr8    = w;
        in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        got_done  = 1'b0;
        got_err   = 1'b0;
        for (int n = 0; n < 40 && !(got_done || got_err); n++) begin
            @(negedge clk);
            got_done = done8;
            got_err  = err8;
        end
    endtask

    task automatic peek8(input logic [4:0] a, input logic [15:0] exp, input string tag);
        dbg_addr8 = a;
        #1;
        check_eq(tag, {16'd0, dbg_data8}, {16'd0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d8, e8;
        int busy;
        rst_n = 1'b0; in_valid = 1'b0; instr = '0; main_addr = '0;
        in_valid8 = 1'b0; instr8 = '0; dbg_addr8 = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_sgpr", {16'd0, sgpr}, 32'd0);
        check_eq("rst_flags", {29'd0, flags}, 32'd0);
        check_eq("rst_pulses", {30'd0, done, err}, 32'd0);
        for (int i = 0; i < 32; i++) peek(5'(i), 16'h0000, "rst_gpr");

        // ADD carry-out and SUB borrow
        send(enc_i(5'd1, 5'd1, 5'd0, 16'hFFFF));
        send(enc_i(5'd2, 5'd2, 5'd1, 16'h0001));
        drain();
        peek(5'd2, 16'h0000, "add_wrap_r2");
        check_eq("add_flags", {29'd0, flags}, {29'd0, 3'b101});
        send(enc_i(5'd3, 5'd3, 5'd2, 16'h0001));
        drain();
        peek(5'd3, 16'hFFFF, "sub_borrow_r3");
        check_eq("sub_flags", {29'd0, flags}, {29'd0, 3'b110});

        // MUL with busy-window length, then MOVSGPR picks up the high word
        send(enc_i(5'd1, 5'd1, 5'd0, 16'h1234));
        send(enc_i(5'd1, 5'd2, 5'd0, 16'h5678));
        send(enc_r(5'd4, 5'd3, 5'd1, 5'd2));
        busy = 0;
        while (!in_ready && busy < 100) begin
            busy++;
            @(negedge clk);
        end
        check_eq("mul_busy_cycles", 32'(busy), 32'(MUL_BUSY));
        drain();
        peek(5'd3, 16'h0060, "mul_lo_r3");
        check_eq("mul_sgpr", {16'd0, sgpr}, 32'h0626);
        send(enc_r(5'd0, 5'd4, 5'd0, 5'd0));
        drain();
        peek(5'd4, 16'h0626, "movsgpr_r4");

        // Illegal opcode: err only, state untouched
        send(enc_r(5'h1F, 5'd1, 5'd2, 5'd3));
        drain();
        peek(5'd1, 16'h1234, "illegal_keeps_r1");
        check_eq("illegal_flags", {29'd0, flags}, 32'd0);

        for (int i = 0; i < 30; i++) send(rand_instr());
        drain();

        // Back-pressure: a new instruction every cycle, accepted only when ready
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            instr    = rand_instr();
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a MUL
        send(enc_i(5'd1, 5'd1, 5'd0, 16'h00F3));
        send(enc_i(5'd1, 5'd2, 5'd0, 16'h0101));
        drain();
        send(enc_r(5'd4, 5'd5, 5'd1, 5'd2));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("midrst_sgpr", {16'd0, sgpr}, 32'd0);
        check_eq("midrst_flags", {29'd0, flags}, 32'd0);
        peek(5'd5, 16'h0000, "midrst_rdst");
        peek(5'd1, 16'h0000, "midrst_r1");
        repeat (25) @(negedge clk);
        check_eq("midrst_no_pending", 32'(sb_q.size()), 32'd0);

        // NREG=8 instance: register index bounds
        run8(enc_r(5'd2, 5'd9, 5'd1, 5'd2), d8, e8);
        check_eq("n8_rdst9_err", {30'd0, d8, e8}, 32'b01);
        peek8(5'd9, 16'h0000, "n8_r9_unreadable");
        run8(enc_i(5'd1, 5'd7, 5'd0, 16'h00AB), d8, e8);
        check_eq("n8_mov_done", {30'd0, d8, e8}, 32'b10);
        peek8(5'd7, 16'h00AB, "n8_r7");
        run8(enc_r(5'd2, 5'd3, 5'd7, 5'd9), d8, e8);
        check_eq("n8_rsrc2_err", {30'd0, d8, e8}, 32'b01);
        peek8(5'd3, 16'h0000, "n8_r3_untouched");
        run8(enc_i(5'd2, 5'd3, 5'd7, 16'hF805), d8, e8);
        check_eq("n8_imm_ignores_rsrc2", {30'd0, d8, e8}, 32'b10);
        peek8(5'd3, 16'hF8B0, "n8_r3_sum");
        run8(enc_r(5'd1, 5'd1, 5'd10, 5'd0), d8, e8);
        check_eq("n8_rsrc1_err", {30'd0, d8, e8}, 32'b01);
        run8(enc_r(5'd4, 5'd6, 5'd7, 5'd7), d8, e8);
        check_eq("n8_mul_done", {30'd0, d8, e8}, 32'b10);
        peek8(5'd6, 16'h7239, "n8_mul_lo");
        check_eq("n8_mul_sgpr", {16'd0, sgpr8}, 32'h0000);

        drain();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
